// File: rtl/axis_histogram_pipe.sv
// Histogram accumulator: each AXI-Stream sample increments one saturating bin counter held in an external simple-dual-port BRAM.
// Latency: handshake t -> porta_addr t+1 -> rddata t+3 -> portb write t+4. A clear sweep takes 2^BRAM_ADDR_WIDTH cycles.
// Backpressure: s_axis_tready = cfg_enable in RUN only. It is low during init, drain and clear. The pipeline itself never stalls.
module axis_histogram_pipe #(
    parameter int AXIS_TDATA_WIDTH = 16,
    parameter int BRAM_DATA_WIDTH  = 32,
    parameter int BRAM_ADDR_WIDTH  = 14,
    parameter int BIN_SHIFT        = 0
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        cfg_enable,
    input  logic                        cfg_clear,
    output logic                        sts_busy,
    output logic                        sts_overflow,
    output logic [31:0]                 sts_count,
    output logic                        s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        bram_porta_clk,
    output logic                        bram_porta_rst,
    output logic [BRAM_ADDR_WIDTH-1:0]  bram_porta_addr,
    input  logic [BRAM_DATA_WIDTH-1:0]  bram_porta_rddata,
    output logic                        bram_portb_clk,
    output logic                        bram_portb_rst,
    output logic [BRAM_ADDR_WIDTH-1:0]  bram_portb_addr,
    output logic [BRAM_DATA_WIDTH-1:0]  bram_portb_wrdata,
    output logic                        bram_portb_we
);

    // The bin field must lie entirely inside the sample word.
    generate
        if (BIN_SHIFT + BRAM_ADDR_WIDTH > AXIS_TDATA_WIDTH) begin : g_bad_bin_field
            $error("axis_histogram_pipe: BIN_SHIFT + BRAM_ADDR_WIDTH exceeds AXIS_TDATA_WIDTH");
        end
    endgenerate

    localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_LAST = '1;
    localparam logic [BRAM_DATA_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [31:0]                STS_MAX   = '1;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // One completed counter write, kept around so later reads of the same bin can be forwarded.
    typedef struct packed {
        logic                       vld;
        logic [BRAM_ADDR_WIDTH-1:0] bin;
        logic [BRAM_DATA_WIDTH-1:0] dat;
    } wr_hist_t;

    state_t                      state_q;
    state_t                      state_d;
    logic                        clear_entry;
    logic                        hs;
    logic [BRAM_ADDR_WIDTH-1:0]  hs_bin;
    logic                        s1_vld;
    logic                        s2_vld;
    logic                        s3_vld;
    logic                        s4_vld;
    logic [BRAM_ADDR_WIDTH-1:0]  s2_bin;
    logic [BRAM_ADDR_WIDTH-1:0]  s3_bin;
    wr_hist_t                    w1_q;
    wr_hist_t                    w2_q;
    logic [BRAM_DATA_WIDTH-1:0]  base_val;
    logic [BRAM_DATA_WIDTH-1:0]  new_val;
    logic                        sat;
    logic                        unused_tdata;

    assign bram_porta_clk = aclk;
    assign bram_porta_rst = areset;
    assign bram_portb_clk = aclk;
    assign bram_portb_rst = areset;

    assign hs           = s_axis_tvalid & s_axis_tready;
    assign hs_bin       = s_axis_tdata[BIN_SHIFT +: BRAM_ADDR_WIDTH];
    // Bits outside the bin field are don't-care for this block.
    assign unused_tdata = ^s_axis_tdata;

    // State register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. DRAIN leaves when S1..S3 are empty, so the last S4 write lands in the final DRAIN cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:  state_d = ST_CLEAR;
            ST_CLEAR: if (!cfg_clear && bram_portb_addr == ADDR_LAST) state_d = ST_RUN;
            ST_RUN:   if (cfg_clear) state_d = ST_DRAIN;
            ST_DRAIN: if (!s1_vld && !s2_vld && !s3_vld) state_d = ST_CLEAR;
            default:  state_d = ST_INIT;
        endcase
    end

    // FSM outputs: sample acceptance and the one-cycle strobe on entering CLEAR.
    always_comb begin
        s_axis_tready = 1'b0;
        clear_entry   = 1'b0;
        if (state_q == ST_RUN) s_axis_tready = cfg_enable;
        if (state_d == ST_CLEAR && state_q != ST_CLEAR) clear_entry = 1'b1;
    end

    // S1..S3: read address issue and two cycles of BRAM read latency. porta_addr doubles as the S1 bin.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            s1_vld          <= 1'b0;
            s2_vld          <= 1'b0;
            s3_vld          <= 1'b0;
            s2_bin          <= '0;
            s3_bin          <= '0;
            bram_porta_addr <= '0;
        end else begin
            s1_vld <= hs;
            s2_vld <= s1_vld;
            s3_vld <= s2_vld;
            s2_bin <= bram_porta_addr;
            s3_bin <= s2_bin;
            if (hs) bram_porta_addr <= hs_bin;
        end
    end

    // S3 base value: the newest in-flight write to the same bin wins over the (possibly stale) BRAM data.
    always_comb begin
        base_val = bram_porta_rddata;
        if (s4_vld && bram_portb_addr == s3_bin) begin
            base_val = bram_portb_wrdata;
        end else if (w1_q.vld && w1_q.bin == s3_bin) begin
            base_val = w1_q.dat;
        end else if (w2_q.vld && w2_q.bin == s3_bin) begin
            base_val = w2_q.dat;
        end
        sat     = (base_val == CNT_MAX);
        new_val = sat ? base_val : base_val + 1'b1;
    end

    // Port B / S4: the clear sweep owns the port in CLEAR; otherwise it carries S4 increments.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            s4_vld            <= 1'b0;
            bram_portb_we     <= 1'b0;
            bram_portb_addr   <= '0;
            bram_portb_wrdata <= '0;
        end else begin
            s4_vld <= s3_vld && (state_d != ST_CLEAR);
            if (state_d == ST_CLEAR) begin
                bram_portb_we     <= 1'b1;
                bram_portb_wrdata <= '0;
                if (state_q != ST_CLEAR || cfg_clear) begin
                    bram_portb_addr <= '0;
                end else begin
                    bram_portb_addr <= bram_portb_addr + 1'b1;
                end
            end else if (s3_vld) begin
                bram_portb_we     <= 1'b1;
                bram_portb_addr   <= s3_bin;
                bram_portb_wrdata <= new_val;
            end else begin
                bram_portb_we <= 1'b0;
            end
        end
    end

    // Forwarding history: the two pipeline writes preceding the current S4 write. Clear writes are not recorded.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w1_q <= '0;
            w2_q <= '0;
        end else begin
            w1_q.vld <= s4_vld;
            w1_q.bin <= bram_portb_addr;
            w1_q.dat <= bram_portb_wrdata;
            w2_q     <= w1_q;
        end
    end

    // Status: busy outside RUN, sticky overflow and saturating sample count, both zeroed on entry to CLEAR.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            sts_busy     <= 1'b1;
            sts_overflow <= 1'b0;
            sts_count    <= '0;
        end else begin
            sts_busy <= (state_d != ST_RUN);
            if (clear_entry) begin
                sts_overflow <= 1'b0;
                sts_count    <= '0;
            end else begin
                if (s3_vld && sat) sts_overflow <= 1'b1;
                if (hs && sts_count != STS_MAX) sts_count <= sts_count + 1'b1;
            end
        end
    end

endmodule
